pwm_fade_ctrl: RTL and testbench

Sequencer for the PWM core: owns the `dvsr` and `duty` inputs of one `pwm_enhanced` instance and ramps the duty cycle between two programmed levels at a programmed rate. It supports a one-shot ramp and a continuous "breathe" (triangle) mode, and runs on the same clock as the PWM core. A one-cycle `period_tick` marks each PWM-period boundary for other logic.

---
 rtl/pwm_fade_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle ramp / breathe sequencer driving the dvsr and duty inputs of a pwm_enhanced core.
// Define PWM_FADE_CYCLE_CNT_EN to add the cycle_cnt output (completed breathe cycles).
module pwm_fade_ctrl #(
    parameter int R  = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] cfg_dvsr,
    input  logic [R:0]    duty_start,
    input  logic [R:0]    duty_end,
    input  logic [R:0]    step,
    input  logic [15:0]   hold_periods,
    input  logic          mode,
    input  logic          start,
    input  logic          stop,
    output logic [DW-1:0] dvsr,
    output logic [R:0]    duty,
    output logic          busy,
    output logic          done,
    output logic          period_tick
`ifdef PWM_FADE_CYCLE_CNT_EN
    ,
    output logic [15:0]   cycle_cnt
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [R:0] MAXD = {1'b1, {R{1'b0}}};

    state_t        state_q, state_d;
    logic [DW-1:0] dvsr_q, dvsr_d;
    logic [R:0]    duty_q, duty_d;
    logic [DW-1:0] q_q, q_d;
    logic [R-1:0]  p_q, p_d;
    logic [15:0]   hold_cnt_q, hold_cnt_d;
    logic          tick_q, tick_d;
    logic          done_q, done_d;
    logic [R:0]    lvl_start_q, lvl_start_d;
    logic [R:0]    lvl_end_q, lvl_end_d;
    logic [R:0]    step_q, step_d;
    logic [15:0]   hold_q, hold_d;
    logic          mode_q, mode_d;
    logic          tgt_end_q, tgt_end_d;
    logic [R:0]    tgt;
    logic [R:0]    nxt_duty;
`ifdef PWM_FADE_CYCLE_CNT_EN
    logic [15:0]   cyc_q, cyc_d;
`endif

    function automatic logic [R:0] clamp_lvl(input logic [R:0] x);
        return (x > MAXD) ? MAXD : x;
    endfunction

    // One step toward tgt, computed one bit wider so neither direction can wrap.
    function automatic logic [R:0] step_toward(input logic [R:0] cur, input logic [R:0] tg,
                                               input logic [R:0] stp);
        logic [R+1:0] c, t, s, n;
        c = {1'b0, cur};
        t = {1'b0, tg};
        s = {1'b0, stp};
        if (t > c) begin
            n = c + s;
            if (n > t) n = t;
        end else if (t < c) begin
            n = (c >= t + s) ? c - s : t;
        end else begin
            n = c;
        end
        return n[R:0];
    endfunction

    assign tgt      = tgt_end_q ? lvl_end_q : lvl_start_q;
    assign nxt_duty = step_toward(duty_q, tgt, step_q);

    always_comb begin
        state_d     = state_q;
        dvsr_d      = dvsr_q;
        duty_d      = duty_q;
        q_d         = q_q;
        p_d         = p_q;
        hold_cnt_d  = hold_cnt_q;
        done_d      = 1'b0;
        lvl_start_d = lvl_start_q;
        lvl_end_d   = lvl_end_q;
        step_d      = step_q;
        hold_d      = hold_q;
        mode_d      = mode_q;
        tgt_end_d   = tgt_end_q;
`ifdef PWM_FADE_CYCLE_CNT_EN
        cyc_d       = cyc_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d     = RUN;
                    dvsr_d      = cfg_dvsr;
                    duty_d      = clamp_lvl(duty_start);
                    lvl_start_d = clamp_lvl(duty_start);
                    lvl_end_d   = clamp_lvl(duty_end);
                    step_d      = (step == '0) ? {{R{1'b0}}, 1'b1} : step;
                    hold_d      = (hold_periods == 16'd0) ? 16'd1 : hold_periods;
                    mode_d      = mode;
                    tgt_end_d   = 1'b1;
                    q_d         = '0;
                    p_d         = '0;
                    hold_cnt_d  = '0;
`ifdef PWM_FADE_CYCLE_CNT_EN
                    cyc_d       = '0;
`endif
                end
            end
            default: begin
                if (stop) begin
                    state_d = IDLE;
                    q_d     = '0;
                    p_d     = '0;
                end else begin
                    if (q_q == dvsr_q) begin
                        q_d = '0;
                        p_d = p_q + 1'b1;
                    end else begin
                        q_d = q_q + 1'b1;
                    end
                    if (tick_q) begin
                        // hold_cnt counts completed periods; expiry on the last one of the hold.
                        if (hold_cnt_q == hold_q - 16'd1) begin
                            hold_cnt_d = '0;
                            duty_d     = nxt_duty;
                            if (nxt_duty == tgt) begin
                                if (mode_q) begin
                                    tgt_end_d = !tgt_end_q;
`ifdef PWM_FADE_CYCLE_CNT_EN
                                    if (!tgt_end_q && cyc_q != 16'hFFFF) cyc_d = cyc_q + 16'd1;
`endif
                                end else begin
                                    state_d = IDLE;
                                    done_d  = 1'b1;
                                    q_d     = '0;
                                    p_d     = '0;
                                end
                            end
                        end else begin
                            hold_cnt_d = hold_cnt_q + 16'd1;
                        end
                    end
                end
            end
        endcase
        // Registered tick: decoded from next-state counters so it lines up with q==dvsr, p==max.
        tick_d = (state_d == RUN) && (q_d == dvsr_d) && (&p_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dvsr_q      <= '0;
            duty_q      <= '0;
            q_q         <= '0;
            p_q         <= '0;
            hold_cnt_q  <= '0;
            tick_q      <= 1'b0;
            done_q      <= 1'b0;
            lvl_start_q <= '0;
            lvl_end_q   <= '0;
            step_q      <= '0;
            hold_q      <= '0;
            mode_q      <= 1'b0;
            tgt_end_q   <= 1'b0;
`ifdef PWM_FADE_CYCLE_CNT_EN
            cyc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            dvsr_q      <= dvsr_d;
            duty_q      <= duty_d;
            q_q         <= q_d;
            p_q         <= p_d;
            hold_cnt_q  <= hold_cnt_d;
            tick_q      <= tick_d;
            done_q      <= done_d;
            lvl_start_q <= lvl_start_d;
            lvl_end_q   <= lvl_end_d;
            step_q      <= step_d;
            hold_q      <= hold_d;
            mode_q      <= mode_d;
            tgt_end_q   <= tgt_end_d;
`ifdef PWM_FADE_CYCLE_CNT_EN
            cyc_q       <= cyc_d;
`endif
        end
    end

    assign dvsr        = dvsr_q;
    assign duty        = duty_q;
    assign busy        = (state_q == RUN);
    assign done        = done_q;
    assign period_tick = tick_q;
`ifdef PWM_FADE_CYCLE_CNT_EN
    assign cycle_cnt   = cyc_q;
`endif

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl: table of single-ramp vectors plus hand-written
// sequences for reset, breathe, stop, start/stop priority and restart in the done cycle.
module tb_pwm_fade_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cfg_dvsr = '0;
    logic [8:0]  duty_start = '0;
    logic [8:0]  duty_end = '0;
    logic [8:0]  step = '0;
    logic [15:0] hold_periods = '0;
    logic        mode = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] dvsr;
    logic [8:0]  duty;
    logic        busy;
    logic        done;
    logic        period_tick;
`ifdef PWM_FADE_CYCLE_CNT_EN
    logic [15:0] cycle_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    pwm_fade_ctrl #(.R(8), .DW(32)) dut (
        .clk(clk), .rst(rst), .cfg_dvsr(cfg_dvsr), .duty_start(duty_start),
        .duty_end(duty_end), .step(step), .hold_periods(hold_periods), .mode(mode),
        .start(start), .stop(stop), .dvsr(dvsr), .duty(duty), .busy(busy),
        .done(done), .period_tick(period_tick)
`ifdef PWM_FADE_CYCLE_CNT_EN
        , .cycle_cnt(cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       dv;
        logic [8:0]        ds;
        logic [8:0]        de;
        logic [8:0]        stp;
        logic [15:0]       hold;
        int                len;
        logic [0:7][8:0]   seq;
    } vec_t;

    vec_t vecs[7];
    logic [8:0] bseq[7] = '{9'd0, 9'd16, 9'd32, 9'd16, 9'd0, 9'd16, 9'd32};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [31:0] dv, input logic [8:0] ds, input logic [8:0] de,
                           input logic [8:0] stp, input logic [15:0] hold, input logic md);
        cfg_dvsr = dv; duty_start = ds; duty_end = de;
        step = stp; hold_periods = hold; mode = md;
    endtask

    task automatic go();
        start = 1'b1;
        step_clk();
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n, hn, total, bad, k;
        logic [8:0] e;
        n     = (int'(v.dv) + 1) * 256;
        hn    = n * ((v.hold == 16'd0) ? 1 : int'(v.hold));
        total = (v.len - 1) * hn;
        bad   = 0;
        set_cfg(v.dv, v.ds, v.de, v.stp, v.hold, 1'b0);
        go();
        check($sformatf("v%0d_busy_start", idx), 32'(busy), 32'd1);
        check($sformatf("v%0d_duty_start", idx), 32'(duty), 32'(v.seq[0]));
        check($sformatf("v%0d_dvsr", idx), dvsr, v.dv);
        for (int c = 0; c <= total; c++) begin
            if (c > 0) step_clk();
            k = c / hn;
            if (k > v.len - 1) k = v.len - 1;
            e = v.seq[k];
            if (duty !== e) bad++;
            if (done !== (c == total)) bad++;
            if (busy !== (c < total)) bad++;
            if (period_tick !== ((c < total) && (((c + 1) % n) == 0))) bad++;
        end
        check($sformatf("v%0d_bad_cycles", idx), 32'(bad), 32'd0);
        check($sformatf("v%0d_done_final", idx), 32'(done), 32'd1);
        check($sformatf("v%0d_duty_final", idx), 32'(duty), 32'(v.seq[v.len-1]));
        step_clk();
        check($sformatf("v%0d_done_once", idx), 32'(done), 32'd0);
        check($sformatf("v%0d_duty_hold", idx), 32'(duty), 32'(v.seq[v.len-1]));
`ifdef PWM_FADE_CYCLE_CNT_EN
        check($sformatf("v%0d_cycle_cnt", idx), 32'(cycle_cnt), 32'd0);
`endif
    endtask

    initial begin
        int bad;
        int dn;

        vecs[0] = '{32'd1, 9'd0,   9'd64,  9'd16,  16'd1, 5,
                    {9'd0, 9'd16, 9'd32, 9'd48, 9'd64, 9'd0, 9'd0, 9'd0}};
        vecs[1] = '{32'd1, 9'd250, 9'd256, 9'd4,   16'd1, 3,
                    {9'd250, 9'd254, 9'd256, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0}};
        vecs[2] = '{32'd1, 9'd100, 9'd0,   9'd40,  16'd0, 4,
                    {9'd100, 9'd60, 9'd20, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0}};
        vecs[3] = '{32'd0, 9'd10,  9'd3,   9'd0,   16'd1, 8,
                    {9'd10, 9'd9, 9'd8, 9'd7, 9'd6, 9'd5, 9'd4, 9'd3}};
        vecs[4] = '{32'd1, 9'd128, 9'd128, 9'd8,   16'd2, 2,
                    {9'd128, 9'd128, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0}};
        vecs[5] = '{32'd2, 9'd0,   9'd255, 9'd200, 16'd1, 3,
                    {9'd0, 9'd200, 9'd255, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0}};
        vecs[6] = '{32'd0, 9'd0,   9'd256, 9'd128, 16'd3, 3,
                    {9'd0, 9'd128, 9'd256, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0}};

        // Power-on reset
        rst = 1'b1;
        repeat (3) step_clk();
        check("por_duty", 32'(duty), 32'd0);
        check("por_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step_clk();

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Reset during RUN
        set_cfg(32'd1, 9'd0, 9'd64, 9'd16, 16'd1, 1'b0);
        go();
        repeat (700) step_clk();
        check("rst_pre_duty", 32'(duty), 32'd16);
        rst = 1'b1;
        step_clk();
        check("rst_duty", 32'(duty), 32'd0);
        check("rst_dvsr", dvsr, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_tick", 32'(period_tick), 32'd0);
        step_clk();
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 2000; c++) begin
            step_clk();
            if (period_tick !== 1'b0 || busy !== 1'b0 || duty !== 9'd0) bad++;
        end
        check("rst_quiet_cycles", 32'(bad), 32'd0);

        // Breathe 0 <-> 32, then stop
        set_cfg(32'd0, 9'd0, 9'd32, 9'd16, 16'd1, 1'b1);
        go();
        bad = 0;
        dn  = 0;
        for (int c = 0; c <= 1586; c++) begin
            if (c > 0) step_clk();
            if (duty !== bseq[c / 256]) bad++;
            if (busy !== 1'b1) bad++;
            if (period_tick !== (((c + 1) % 256) == 0)) bad++;
            if (done) dn++;
`ifdef PWM_FADE_CYCLE_CNT_EN
            if (c == 1023) check("brth_cnt_before", 32'(cycle_cnt), 32'd0);
            if (c == 1024) check("brth_cnt_after", 32'(cycle_cnt), 32'd1);
`endif
        end
        check("brth_bad_cycles", 32'(bad), 32'd0);
        check("brth_no_done", 32'(dn), 32'd0);
        stop = 1'b1;
        step_clk();
        stop = 1'b0;
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_duty", 32'(duty), 32'd32);
        check("stop_done", 32'(done), 32'd0);
        bad = 0;
        for (int c = 0; c < 600; c++) begin
            step_clk();
            if (duty !== 9'd32 || busy !== 1'b0 || period_tick !== 1'b0 || done !== 1'b0) bad++;
        end
        check("stop_frozen_cycles", 32'(bad), 32'd0);

        // Start while busy is ignored
        set_cfg(32'd1, 9'd0, 9'd64, 9'd16, 16'd1, 1'b0);
        go();
        repeat (100) step_clk();
        set_cfg(32'd5, 9'd200, 9'd0, 9'd50, 16'd3, 1'b1);
        go();
        check("busy_start_duty", 32'(duty), 32'd0);
        check("busy_start_dvsr", dvsr, 32'd1);
        repeat (411) step_clk();
        check("busy_step1_duty", 32'(duty), 32'd16);
        repeat (512) step_clk();
        check("busy_step2_duty", 32'(duty), 32'd32);
        stop = 1'b1;
        step_clk();
        stop = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);

        // start together with stop in IDLE
        set_cfg(32'd0, 9'd77, 9'd90, 9'd1, 16'd1, 1'b0);
        start = 1'b1;
        stop  = 1'b1;
        step_clk();
        start = 1'b0;
        stop  = 1'b0;
        check("prio_busy", 32'(busy), 32'd0);
        check("prio_duty", 32'(duty), 32'd32);
        step_clk();
        check("prio_busy_later", 32'(busy), 32'd0);

        // New start accepted in the done cycle
        set_cfg(32'd0, 9'd128, 9'd128, 9'd1, 16'd1, 1'b0);
        go();
        repeat (256) step_clk();
        check("dc_done", 32'(done), 32'd1);
        set_cfg(32'd0, 9'd0, 9'd16, 9'd16, 16'd1, 1'b0);
        go();
        check("dc_busy", 32'(busy), 32'd1);
        check("dc_duty", 32'(duty), 32'd0);
        repeat (256) step_clk();
        check("dc_final_duty", 32'(duty), 32'd16);
        check("dc_final_done", 32'(done), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
